// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// master drives operands and out_ready; slave is the adder itself.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder and a carry flop, LSB first, one bit per clock,
// wrapped in an IDLE/ADD/DONE valid-ready controller.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  localparam logic [5:0] LastCnt = 6'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_shift;
  logic [5:0]       cnt_q;
  logic             carry_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic ha0_s, ha0_c, ha1_c, fa_sum, fa_cout;

  // Full adder built from two half adders on the current LSBs.
  assign ha0_s   = a_q[0] ^ b_q[0];
  assign ha0_c   = a_q[0] & b_q[0];
  assign fa_sum  = ha0_s ^ carry_q;
  assign ha1_c   = ha0_s & carry_q;
  assign fa_cout = ha0_c | ha1_c;

  // New result bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_res_w1
    assign res_shift = fa_sum;
  end else begin : g_res_wn
    assign res_shift = {fa_sum, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            carry_q    <= bus.cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StAdd;
          end
        end
        StAdd: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_shift;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + 6'd1;
          if (cnt_q == LastCnt) begin
            // carry_q here is the carry into the MSB.
            ovf_q       <= carry_q ^ fa_cout;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = res_q;
  assign bus.cout      = carry_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: 8-bit scenarios plus an exhaustive 4-bit sweep.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one 8-bit operation with out_ready=1; called and returns at a negedge in IDLE.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int lat, output int busy_n, output int acc_cyc);
    bus8.a = av; bus8.b = bv; bus8.cin = cv; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    bus8.in_valid = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!bus8.out_valid && lat < 40) begin
      if (bus8.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    s = bus8.sum; co = bus8.cout; ov = bus8.ovf;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus8.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", bus8.in_ready);
    end
    n_checks++;
    if ({bus8.out_valid, bus8.busy, bus8.cout, bus8.ovf} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got ov/busy/cout/ovf=%b expected 0000",
               {bus8.out_valid, bus8.busy, bus8.cout, bus8.ovf});
    end
    n_checks++;
    if (bus8.sum !== 8'h00) begin
      n_fail++; $display("FAIL reset_sum: got %h expected 00", bus8.sum);
    end
    n_checks++;
    if ({bus4.in_ready, bus4.out_valid, bus4.sum} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++; $display("FAIL reset_w4: got rdy=%0b vld=%0b sum=%h expected 1 0 0",
                         bus4.in_ready, bus4.out_valid, bus4.sum);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_carry_wrap;
    logic [7:0] s; logic co, ov; int lat, bn, acc;
    do_op8(8'hFF, 8'h01, 1'b0, s, co, ov, lat, bn, acc);
    n_checks++;
    if ({co, s, ov} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL wrap_result: got cout=%0b sum=%h ovf=%0b expected 1 00 0",
                         co, s, ov);
    end
    n_checks++;
    if (lat !== 8) begin
      n_fail++; $display("FAIL wrap_latency: got %0d expected 8", lat);
    end
    n_checks++;
    if (bn !== 8) begin
      n_fail++; $display("FAIL wrap_busy_cycles: got %0d expected 8", bn);
    end
    n_checks++;
    if ({bus8.out_valid, bus8.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL wrap_drain: got vld=%0b rdy=%0b expected 0 1",
                         bus8.out_valid, bus8.in_ready);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] s; logic co, ov; int lat, bn, acc;
    do_op8(8'h7F, 8'h01, 1'b0, s, co, ov, lat, bn, acc);
    n_checks++;
    if ({co, s, ov} !== {1'b0, 8'h80, 1'b1}) begin
      n_fail++; $display("FAIL ovf_pos: got cout=%0b sum=%h ovf=%0b expected 0 80 1", co, s, ov);
    end
    do_op8(8'h80, 8'h80, 1'b1, s, co, ov, lat, bn, acc);
    n_checks++;
    if ({co, s, ov} !== {1'b1, 8'h01, 1'b1}) begin
      n_fail++; $display("FAIL ovf_neg: got cout=%0b sum=%h ovf=%0b expected 1 01 1", co, s, ov);
    end
  endtask

  task automatic test_backpressure;
    int n;
    // 0x3C + 0x55 + 1 = 0x92: carry into MSB set, no cout, signed overflow.
    bus8.a = 8'h3C; bus8.b = 8'h55; bus8.cin = 1'b1; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    @(negedge clk);
    n = 0;
    while (!bus8.out_valid && n < 40) begin
      n_checks++;
      if (bus8.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_add_in_ready: got %0b expected 0", bus8.in_ready);
      end
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      bus8.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== 8) begin
      n_fail++; $display("FAIL bp_latency: got %0d expected 8", n);
    end
    repeat (5) begin
      n_checks++;
      if ({bus8.out_valid, bus8.in_ready, bus8.sum, bus8.cout, bus8.ovf}
          !== {1'b1, 1'b0, 8'h92, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_hold: got vld=%0b rdy=%0b sum=%h cout=%0b ovf=%0b expected 1 0 92 0 1",
                 bus8.out_valid, bus8.in_ready, bus8.sum, bus8.cout, bus8.ovf);
      end
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.in_valid = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if ({bus8.out_valid, bus8.sum} !== {1'b1, 8'h92}) begin
      n_fail++; $display("FAIL bp_hold_last: got vld=%0b sum=%h expected 1 92",
                         bus8.out_valid, bus8.sum);
    end
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus8.out_valid, bus8.in_ready, bus8.busy} !== 3'b010) begin
      n_fail++; $display("FAIL bp_drain: got vld/rdy/busy=%b expected 010",
                         {bus8.out_valid, bus8.in_ready, bus8.busy});
    end
  endtask

  task automatic test_async_abort;
    logic [7:0] s; logic co, ov; int lat, bn, acc; bit seen;
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus8.busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre_busy: got %0b expected 1", bus8.busy);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus8.out_valid, bus8.in_ready, bus8.busy, bus8.sum} !== {3'b010, 8'h00}) begin
      n_fail++; $display("FAIL abort_async: got vld=%0b rdy=%0b busy=%0b sum=%h expected 0 1 0 00",
                         bus8.out_valid, bus8.in_ready, bus8.busy, bus8.sum);
    end
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL abort_stale: got out_valid seen=1 expected 0");
    end
    do_op8(8'h12, 8'h34, 1'b0, s, co, ov, lat, bn, acc);
    n_checks++;
    if ({co, s, ov, lat} !== {1'b0, 8'h46, 1'b0, 32'd8}) begin
      n_fail++; $display("FAIL abort_next_op: got cout=%0b sum=%h ovf=%0b lat=%0d expected 0 46 0 8",
                         co, s, ov, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] s; logic co, ov; int lat, bn, acc1, acc2, n;
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    @(negedge clk);
    acc1 = cyc;
    bus8.in_valid = 1'b0;
    n = 0;
    while (!bus8.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if ({bus8.out_valid, bus8.sum} !== {1'b1, 8'h30}) begin
      n_fail++; $display("FAIL b2b_first: got vld=%0b sum=%h expected 1 30", bus8.out_valid, bus8.sum);
    end
    // Valid and ready together in DONE: only the result is consumed on this edge.
    bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b1; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus8.out_valid, bus8.in_ready, bus8.busy} !== 3'b010) begin
      n_fail++; $display("FAIL b2b_consume_only: got vld/rdy/busy=%b expected 010",
                         {bus8.out_valid, bus8.in_ready, bus8.busy});
    end
    @(negedge clk);
    acc2 = cyc;
    bus8.in_valid = 1'b0;
    n_checks++;
    if ({bus8.busy, bus8.in_ready} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%0b rdy=%0b expected 1 0",
                         bus8.busy, bus8.in_ready);
    end
    n_checks++;
    if (acc2 - acc1 !== 10) begin
      n_fail++; $display("FAIL b2b_spacing_done: got %0d expected 10", acc2 - acc1);
    end
    n = 0;
    while (!bus8.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if ({bus8.cout, bus8.sum, bus8.ovf, n} !== {1'b0, 8'h04, 1'b0, 32'd8}) begin
      n_fail++; $display("FAIL b2b_second: got cout=%0b sum=%h ovf=%0b lat=%0d expected 0 04 0 8",
                         bus8.cout, bus8.sum, bus8.ovf, n);
    end
    @(negedge clk);
    do_op8(8'h05, 8'h06, 1'b0, s, co, ov, lat, bn, acc1);
    do_op8(8'hF0, 8'h0F, 1'b1, s, co, ov, lat, bn, acc2);
    n_checks++;
    if (acc2 - acc1 !== 10) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d expected 10", acc2 - acc1);
    end
    n_checks++;
    if ({co, s, ov} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL b2b_third: got cout=%0b sum=%h ovf=%0b expected 1 00 0", co, s, ov);
    end
  endtask

  task automatic test_exhaustive_w4;
    int exp_u, exp_s, sa, sb, n;
    logic exp_ovf;
    bit got;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          exp_u = ai + bi + ci;
          sa = (ai >= 8) ? ai - 16 : ai;
          sb = (bi >= 8) ? bi - 16 : bi;
          exp_s = sa + sb + ci;
          exp_ovf = (exp_s > 7) || (exp_s < -8);
          bus4.a = 4'(ai); bus4.b = 4'(bi); bus4.cin = 1'(ci); bus4.in_valid = 1'b1;
          bus4.out_ready = 1'($urandom_range(0, 1));
          got = 1'b0;
          n = 0;
          while (n < 60) begin
            @(negedge clk);
            bus4.in_valid = 1'b0;
            n++;
            if (!got && bus4.out_valid) begin
              got = 1'b1;
              n_checks++;
              if ({bus4.cout, bus4.sum, bus4.ovf} !== {5'(exp_u), exp_ovf}) begin
                n_fail++;
                $display("FAIL w4_sum a=%h b=%h c=%0d: got cout=%0b sum=%h ovf=%0b expected %h ovf=%0b",
                         ai, bi, ci, bus4.cout, bus4.sum, bus4.ovf, 5'(exp_u), exp_ovf);
              end
            end else if (got && !bus4.out_valid) begin
              break;
            end
            bus4.out_ready = 1'($urandom_range(0, 1));
          end
          if (n >= 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL w4_timeout a=%h b=%h c=%0d: got no drain expected drain", ai, bi, ci);
          end
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
    test_reset();
    test_carry_wrap();
    test_overflow();
    test_backpressure();
    test_async_abort();
    test_back_to_back();
    test_exhaustive_w4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
